// File: rtl/cp0_except_unit.sv
// cp0_except_unit
//   Coprocessor-0 register file and exception-source unit that sits beside
//   the MEM stage. Holds Status, Cause, EPC, Count and Compare, prioritises
//   interrupts over synchronous exceptions, and commits exception state on
//   the rising clock edge unless the pipeline is stalled.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   hw_int[5:0]        : level hardware interrupts (IP[7:2])
//   mem_valid, mem_pc  : MEM-stage instruction valid flag and PC
//   mem_is_*           : decoded syscall / RI / overflow / trap / eret flags
//   mem_stall          : pipeline hold, blocks all exception commits
//   cp0_we, cp0_waddr, cp0_wdata : mtc0 write port (WB stage)
//   cp0_raddr, cp0_rdata         : combinational read port
//   mem_excepttype     : exception code to the control unit (0 = none)
//   epc_out            : current EPC, the eret target
//   timer_int          : Count/Compare match flag (IP[7])
//
// Configuration
//   CP0_TIMER_EN : when defined, builds Count/Compare and routes timer_int to
//                  IP[7]; otherwise Count/Compare read 0 and IP[7] = hw_int[5].
module cp0_except_unit #(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_syscall,
  input  logic        mem_is_ri,
  input  logic        mem_is_ov,
  input  logic        mem_is_trap,
  input  logic        mem_is_eret,
  input  logic        mem_stall,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] mem_excepttype,
  output logic [31:0] epc_out,
  output logic        timer_int
);

  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        timer_q;
  logic        ip7;
  logic [7:0]  ip;
  logic [7:0]  pending;
  logic        int_ok;
  logic [31:0] code;
  logic [4:0]  new_exc_code;
  logic        commit;
  logic        commit_eret;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  assign wr_status  = cp0_we && (cp0_waddr == 5'd12);
  assign wr_cause   = cp0_we && (cp0_waddr == 5'd13);
  assign wr_epc     = cp0_we && (cp0_waddr == 5'd14);
  assign wr_count   = cp0_we && (cp0_waddr == 5'd9);
  assign wr_compare = cp0_we && (cp0_waddr == 5'd11);

`ifdef CP0_TIMER_EN
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] compare_q;
  logic [COUNT_W-1:0] count_next;

  assign count_next = wr_count ? cp0_wdata[COUNT_W-1:0] : count_q + 1'b1;

  // Timer match is against the pre-edge Compare; a Compare write always
  // clears the flag, even if the same edge would otherwise match.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      if (wr_compare) begin
        compare_q <= cp0_wdata[COUNT_W-1:0];
        timer_q   <= 1'b0;
      end else if (count_next == compare_q) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign ip7        = timer_q;
  assign count_rd   = 32'(count_q);
  assign compare_rd = 32'(compare_q);
`else
  localparam logic [COUNT_W-1:0] COUNT_ZERO = '0;

  assign timer_q    = 1'b0;
  assign ip7        = hw_int[5];
  assign count_rd   = 32'(COUNT_ZERO);
  assign compare_rd = 32'(COUNT_ZERO);
`endif

  assign ip      = {ip7, hw_int[4:0], ip_sw};
  assign pending = ip & status_im;
  assign int_ok  = status_ie && !status_exl && (pending != 8'd0);

  // Interrupts outrank synchronous exceptions; among interrupts the lowest
  // pending IP bit wins, so the loop scans downward and the last hit sticks.
  always_comb begin
    code = 32'd0;
    if (!reset && mem_valid) begin
      if (int_ok) begin
        for (int k = 7; k >= 0; k--) begin
          if (pending[k]) code = 32'(k + 1);
        end
      end else if (mem_is_ri)      code = 32'h0a;
      else if (mem_is_syscall)     code = 32'h09;
      else if (mem_is_trap)        code = 32'h0c;
      else if (mem_is_ov)          code = 32'h0b;
      else if (mem_is_eret)        code = 32'h0d;
    end
  end

  always_comb begin
    new_exc_code = 5'd0;
    case (code)
      32'h09:  new_exc_code = 5'd8;
      32'h0a:  new_exc_code = 5'd10;
      32'h0b:  new_exc_code = 5'd12;
      32'h0c:  new_exc_code = 5'd13;
      default: new_exc_code = 5'd0;
    endcase
  end

  assign commit      = !mem_stall && (code != 32'd0);
  assign commit_eret = commit && (code == 32'h0d);

  // A same-edge commit overrides mtc0 only on the fields it updates (EXL,
  // EPC, ExcCode); IE, IM and the software IP bits still take the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
      status_im  <= 8'd0;
      ip_sw      <= 2'd0;
      exc_code   <= 5'd0;
      epc        <= 32'd0;
    end else begin
      if (wr_status) begin
        status_ie <= cp0_wdata[0];
        status_im <= cp0_wdata[15:8];
      end
      if (commit_eret)    status_exl <= 1'b0;
      else if (commit)    status_exl <= 1'b1;
      else if (wr_status) status_exl <= cp0_wdata[1];
      if (wr_cause) ip_sw <= cp0_wdata[9:8];
      if (commit && !commit_eret) begin
        exc_code <= new_exc_code;
        epc      <= mem_pc;
      end else if (wr_epc) begin
        epc <= cp0_wdata;
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      5'd9:    cp0_rdata = count_rd;
      5'd11:   cp0_rdata = compare_rd;
      5'd12:   cp0_rdata = {16'd0, status_im, 6'd0, status_exl, status_ie};
      5'd13:   cp0_rdata = {16'd0, ip, 1'b0, exc_code, 2'd0};
      5'd14:   cp0_rdata = epc;
      default: cp0_rdata = 32'd0;
    endcase
  end

  assign mem_excepttype = code;
  assign epc_out        = reset ? 32'd0 : epc;
  assign timer_int      = timer_q;

endmodule

// File: doc/cp0_except_unit.md
# cp0_except_unit

Coprocessor-0 and exception-source unit for the five-stage pipeline. It sits beside the MEM stage and drives `mem_excepttype` and the return address consumed by the pipeline control unit. It also honours that unit's `mem_stall` hold. It owns Status, Cause, EPC, Count and Compare, prioritises interrupts and synchronous exceptions, and commits exception state on the clock edge.

## Interface

Parameters:
- `COUNT_W`, default 32: width of Count/Compare.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hw_int`  in  6  level hardware interrupt lines, mapped to IP[7:2].
- `mem_valid`  in  1  the MEM stage holds a real instruction, not a bubble.
- `mem_pc`  in  32  PC of the MEM-stage instruction.
- `mem_is_syscall`, `mem_is_ri`, `mem_is_ov`, `mem_is_trap`, `mem_is_eret`  in  1 each  decoded or raised conditions of the MEM instruction.
- `mem_stall`  in  1  pipeline hold; no CP0 commit while high.
- `cp0_we`  in  1  WB-stage `mtc0` write strobe.
- `cp0_waddr`, `cp0_raddr`  in  5  CP0 register numbers.
- `cp0_wdata`  in  32  write data.
- `cp0_rdata`  out  32  combinational read of `cp0_raddr`.
- `mem_excepttype`  out  32  exception code for the control unit; 0 means none.
- `epc_out`  out  32  current EPC, used as the `eret` target.
- `timer_int`  out  1  timer pending flag (IP[7]).

## Operation

Register map:
- 9 Count; 11 Compare; 12 Status; 13 Cause; 14 EPC.
- Other addresses read 0 and ignore writes.

Status bits:
- [0] IE, [1] EXL, [15:8] IM.
- All other bits read 0.

Cause bits:
- [15:8] IP. IP[1:0] are software-writable. IP[6:2] = `hw_int[4:0]` live. IP[7] = `timer_int`.
- [6:2] ExcCode.
- All other bits read 0.

Exception code generation (combinational; forced to 0 when `reset` or `!mem_valid`):
- An interrupt is eligible when IE=1, EXL=0, and (IP & IM) ≠ 0. The lowest set bit *k* gives code *k*+1 (0x1–0x8).
- Otherwise, with RI > syscall > trap > ov > eret: 0xa, 0x9, 0xc, 0xb, 0xd.

Commit, on an edge with `!mem_stall` and code ≠ 0:
- Codes 0x1–0xc: EPC ← `mem_pc`; EXL ← 1.
- ExcCode ← Int 0 / Sys 8 / RI 10 / Ov 12 / Tr 13.
- Code 0xd (eret): EXL ← 0; EPC unchanged.

`mtc0`:
- Writes take effect on the edge.
- A same-edge exception commit overrides writes to the Status, Cause and EPC fields it updates; Count and Compare writes still land.

Count and timer:
- Count increments by 1 every edge (mod 2^COUNT_W).
- A Count write loads `cp0_wdata` instead of incrementing.
- When the next Count equals Compare, `timer_int` ← 1.
- Any Compare write clears `timer_int`; a Compare write wins over a same-edge match.

## Timing

- `mem_excepttype`, `cp0_rdata` and `epc_out` are combinational from registers and inputs, with zero latency.
- EPC, EXL and ExcCode reflect a commit one cycle after it.
- While `mem_stall` is high:
  - `mem_excepttype` may be nonzero but nothing commits.
  - The code re-evaluates after release.
- Because EXL=1 the cycle after an exception commit, no nested interrupt is taken until `eret` commits.
- Reset values: Status=0, Cause=0, EPC=0, Count=0, Compare=0, `timer_int`=0.
  - Output `mem_excepttype`=0 during reset.
  - Output `epc_out`=0 during reset.
- Reset asserted mid-operation discards any same-cycle commit.

## Configuration

`CP0_TIMER_EN`:
- **Defined:** the Count/Compare timer is built, and IP[7] = `timer_int`.
- **Undefined:**
  - Count and Compare read 0 and ignore writes.
  - `timer_int` is tied to 0.
  - IP[7] = `hw_int[5]`.

## Test plan

- Reset, then IE=1, IM=0xff, `hw_int`=6'b000100 with a valid instruction at PC 0x400 -> `mem_excepttype`=0x5; next cycle EPC=0x400, EXL=1, ExcCode=0.
- `mem_is_ri`=1 and `mem_is_syscall`=1 at PC 0x800 with `mem_stall`=1 for 3 cycles -> code 0xa held and EPC unchanged; after release EPC=0x800, ExcCode=10.
- With EXL=1 and EPC=0x800, `mem_is_eret`=1 -> code 0xd, `epc_out`=0x800; next cycle EXL=0.
- Compare ← 5 and Count ← 0 -> `timer_int` rises on the edge where Count becomes 5; a Compare write clears it. Without `CP0_TIMER_EN`, Count reads 0 and `hw_int[5]` gives code 0x8.
- Same-edge `mtc0` to EPC (0x1234) and an overflow commit at PC 0x900 -> EPC=0x900, ExcCode=12.
